// File: rtl/fusion_seq_ctrl.sv
// Sequencer for one 4b x 4b fusion_unit: splits 2/4/8-bit operand pairs into 1, 2 or 4
// nibble passes and shift-accumulates the returned psums into a dot-product result.
module fusion_seq_ctrl #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [7:0]       w_data,
  input  logic [1:0]       in_prec,
  input  logic [1:0]       w_prec,
  input  logic             s_in,
  input  logic             s_weight,
  input  logic             in_last,
  output logic [3:0]       fu_in,
  output logic [3:0]       fu_weight,
  output logic [2:0]       fu_in_width,
  output logic [2:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [17:0]      fu_psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t           r_state;
  logic [7:0]       r_a, r_w;
  logic             r_a8, r_w8, r_sa, r_sw, r_last;
  logic [1:0]       r_k;
  logic [3:0]       r_fu_in, r_fu_weight;
  logic             r_fu_s_in, r_fu_s_weight;
  logic             r_fu_vld;
  logic [1:0]       r_fu_sh;
  logic             r_ps_vld, r_ps_sgn;
  logic [1:0]       r_ps_sh;
  logic [ACC_W-1:0] r_acc, r_out_data;
  logic             r_out_valid, r_in_ready, r_busy;

  logic             w_idle;
  logic [7:0]       w_a, w_w;
  logic             w_a8, w_w8, w_sa, w_sw;
  logic [1:0]       w_k, w_last_k, w_sh;
  logic             w_i_hi, w_w_hi;
  logic [3:0]       w_nib_i, w_nib_w;
  logic             w_si, w_sw_pass;
  logic [ACC_W-1:0] w_ps_ext, w_acc_sum;

  // Narrow operands are extended into the low nibble; upper bits of the bus are ignored.
  function automatic logic [7:0] ext_op(input logic [7:0] d, input logic [1:0] prec,
                                        input logic s);
    case (prec)
      2'd0:    return {4'h0, {2{s & d[1]}}, d[1:0]};
      2'd1:    return {4'h0, d[3:0]};
      default: return d;
    endcase
  endfunction

  // Pass selection: in IDLE the incoming pair's pass 0, otherwise the latched pair's pass k+1.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_a       = w_idle ? ext_op(in_data, in_prec, s_in)  : r_a;
    w_w       = w_idle ? ext_op(w_data, w_prec, s_weight) : r_w;
    w_a8      = w_idle ? in_prec[1] : r_a8;
    w_w8      = w_idle ? w_prec[1]  : r_w8;
    w_sa      = w_idle ? s_in       : r_sa;
    w_sw      = w_idle ? s_weight   : r_sw;
    w_k       = w_idle ? 2'd0 : r_k + 2'd1;
    w_i_hi    = w_a8 & w_k[0];
    w_w_hi    = w_w8 & (w_a8 ? w_k[1] : w_k[0]);
    w_nib_i   = w_i_hi ? w_a[7:4] : w_a[3:0];
    w_nib_w   = w_w_hi ? w_w[7:4] : w_w[3:0];
    w_si      = w_sa & (w_i_hi | ~w_a8);
    w_sw_pass = w_sw & (w_w_hi | ~w_w8);
    w_sh      = {1'b0, w_i_hi} + {1'b0, w_w_hi};
    w_last_k  = (r_a8 & r_w8) ? 2'd3 : ((r_a8 | r_w8) ? 2'd1 : 2'd0);
    w_ps_ext  = r_ps_sgn ? ACC_W'($signed(fu_psum)) : ACC_W'(fu_psum);
    w_acc_sum = r_acc + (r_ps_vld ? (w_ps_ext << {r_ps_sh, 2'b00}) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_w           <= '0;
      r_a8          <= 1'b0;
      r_w8          <= 1'b0;
      r_sa          <= 1'b0;
      r_sw          <= 1'b0;
      r_last        <= 1'b0;
      r_k           <= '0;
      r_fu_in       <= '0;
      r_fu_weight   <= '0;
      r_fu_s_in     <= 1'b0;
      r_fu_s_weight <= 1'b0;
      r_fu_vld      <= 1'b0;
      r_fu_sh       <= '0;
      r_ps_vld      <= 1'b0;
      r_ps_sgn      <= 1'b0;
      r_ps_sh       <= '0;
      r_acc         <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      // The fusion_unit registers psum one cycle after issue; track which pass it belongs to.
      r_ps_vld <= r_fu_vld;
      r_ps_sh  <= r_fu_sh;
      r_ps_sgn <= r_fu_s_in | r_fu_s_weight;
      r_acc    <= w_acc_sum;

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a           <= w_a;
            r_w           <= w_w;
            r_a8          <= w_a8;
            r_w8          <= w_w8;
            r_sa          <= s_in;
            r_sw          <= s_weight;
            r_last        <= in_last;
            r_k           <= 2'd0;
            r_fu_in       <= w_nib_i;
            r_fu_weight   <= w_nib_w;
            r_fu_s_in     <= w_si;
            r_fu_s_weight <= w_sw_pass;
            r_fu_vld      <= 1'b1;
            r_fu_sh       <= w_sh;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_k == w_last_k) begin
            r_fu_in       <= '0;
            r_fu_weight   <= '0;
            r_fu_s_in     <= 1'b0;
            r_fu_s_weight <= 1'b0;
            r_fu_vld      <= 1'b0;
            r_fu_sh       <= '0;
            r_state       <= S_DRAIN;
          end else begin
            r_k           <= w_k;
            r_fu_in       <= w_nib_i;
            r_fu_weight   <= w_nib_w;
            r_fu_s_in     <= w_si;
            r_fu_s_weight <= w_sw_pass;
            r_fu_sh       <= w_sh;
          end
        end
        S_DRAIN: begin
          if (r_last) begin
            r_out_data  <= w_acc_sum;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_state     <= S_OUT;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign busy            = r_busy;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign fu_in           = r_fu_in;
  assign fu_weight       = r_fu_weight;
  assign fu_s_in         = r_fu_s_in;
  assign fu_s_weight     = r_fu_s_weight;
  assign fu_in_width     = 3'b100;
  assign fu_weight_width = 3'b100;

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Bench for fusion_seq_ctrl: behavioural fusion_unit plus directed vector table and
// hand-written sequences for dot products, back-pressure and mid-operation reset.
module tb_fusion_seq_ctrl;
  localparam int unsigned ACC_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic [7:0]       w_data = '0;
  logic [1:0]       in_prec = '0;
  logic [1:0]       w_prec = '0;
  logic             s_in = 1'b0;
  logic             s_weight = 1'b0;
  logic             in_last = 1'b0;
  logic [3:0]       fu_in, fu_weight;
  logic [2:0]       fu_in_width, fu_weight_width;
  logic             fu_s_in, fu_s_weight;
  logic [17:0]      fu_psum;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  fusion_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_data(w_data), .in_prec(in_prec), .w_prec(w_prec),
    .s_in(s_in), .s_weight(s_weight), .in_last(in_last),
    .fu_in(fu_in), .fu_weight(fu_weight), .fu_in_width(fu_in_width),
    .fu_weight_width(fu_weight_width), .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight),
    .fu_psum(fu_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // Behavioural fusion_unit: registered signed/unsigned 4b x 4b product.
  logic signed [17:0] m_a, m_b;
  assign m_a = fu_s_in     ? 18'($signed(fu_in))     : 18'(fu_in);
  assign m_b = fu_s_weight ? 18'($signed(fu_weight)) : 18'(fu_weight);
  always @(posedge clk) begin
    if (reset) fu_psum <= '0;
    else       fu_psum <= 18'(m_a * m_b);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] w;
    logic [1:0] pa;
    logic [1:0] pw;
    logic       sa;
    logic       sw;
    logic       last;
    int         exp;
    int         p;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)",
                              name, act, $signed(act), exp, $signed(exp));
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa,
                              input logic [1:0] pw, input logic sa, input logic sw,
                              input logic last, input int exp, input int p);
    vec_t v;
    v.a = a; v.w = w; v.pa = pa; v.pw = pw; v.sa = sa; v.sw = sw;
    v.last = last; v.exp = exp; v.p = p;
    return v;
  endfunction

  // Present a pair while in IDLE; returns #1 after the accepting edge.
  task automatic send(input vec_t v);
    in_data = v.a; w_data = v.w; in_prec = v.pa; w_prec = v.pw;
    s_in = v.sa; s_weight = v.sw; in_last = v.last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Run until the controller is back in IDLE; lat = edges after accept until out_valid (-1 if none).
  task automatic finish_pair(output int lat, output logic [31:0] res);
    lat = -1; res = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (out_valid && lat < 0) begin lat = c; res = out_data; end
      if (in_ready) break;
    end
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic do_pair(input vec_t v, output int lat, output logic [31:0] res);
    send(v);
    finish_pair(lat, res);
  endtask

  int          lat, lat1, lat2;
  logic [31:0] res;
  logic [9:0]  exp_pass [4];
  vec_t        v;

  initial begin
    // All vectors close a dot product; lat = P+1 edges after accept (P+2 cycles incl. accept).
    tbl[0] = mk(8'h07, 8'h09, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 63,     1);
    tbl[1] = mk(8'h80, 8'h7F, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, -16256, 4);
    tbl[2] = mk(8'hC8, 8'h0D, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, -600,   2);
    tbl[3] = mk(8'h02, 8'h05, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, -10,    1);
    tbl[4] = mk(8'h09, 8'hFF, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, -1785,  2);
    tbl[5] = mk(8'hFF, 8'hFF, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 65025,  4);
    tbl[6] = mk(8'hFF, 8'hF3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, -3,     1);
    tbl[7] = mk(8'hFF, 8'hFF, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1,      4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_fu",        32'({fu_in, fu_weight, fu_s_in, fu_s_weight}), 32'd0);
    chk("fu_widths",     32'({fu_in_width, fu_weight_width}), 32'({3'b100, 3'b100}));
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_pair(tbl[i], lat, res);
      chk($sformatf("vec%0d_data", i), res, 32'(tbl[i].exp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].p + 1));
    end

    // 8x8 signed: per-pass nibbles and signs {fu_in, fu_weight, fu_s_in, fu_s_weight}.
    exp_pass[0] = {4'h0, 4'hF, 1'b0, 1'b0};
    exp_pass[1] = {4'h8, 4'hF, 1'b1, 1'b0};
    exp_pass[2] = {4'h0, 4'h7, 1'b0, 1'b1};
    exp_pass[3] = {4'h8, 4'h7, 1'b1, 1'b1};
    send(tbl[1]);
    chk("issue_in_ready", 32'(in_ready), 32'd0);
    chk("issue_busy",     32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pass%0d_fu", k), 32'({fu_in, fu_weight, fu_s_in, fu_s_weight}),
          32'(exp_pass[k]));
      if (k < 3) begin @(posedge clk); #1; end
    end
    finish_pair(lat, res);
    chk("pass_seq_data", res, 32'(-16256));

    // Dot product (3x4)+(-5x6)+(100x-2): only the closing pair yields a result.
    do_pair(mk(8'h03, 8'h04, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 0, 1), lat1, res);
    do_pair(mk(8'h0B, 8'h06, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 0, 1), lat2, res);
    chk("dot_no_early_1", 32'(lat1), 32'(-1));
    chk("dot_no_early_2", 32'(lat2), 32'(-1));
    do_pair(mk(8'h64, 8'h0E, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 0, 2), lat, res);
    chk("dot_data", res, 32'(-218));
    chk("dot_lat",  32'(lat), 32'd3);

    // Back-pressure: result held for 5 cycles, then the next result starts from zero.
    out_ready = 1'b0;
    send(mk(8'h05, 8'h05, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 0, 1));
    for (int c = 0; c < 10; c++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data",  out_data, 32'd25);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_ctl", c), 32'({out_valid, in_ready, busy}), 32'(3'b101));
      chk($sformatf("bp_hold%0d_data", c), out_data, 32'd25);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({out_valid, in_ready, busy}), 32'(3'b010));
    do_pair(mk(8'h04, 8'h04, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 0, 1), lat, res);
    chk("bp_next_data", res, 32'd16);

    // Reset while pass 2 of an 8x8 is on the fusion_unit inputs.
    v = mk(8'h55, 8'h55, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 0, 4);
    send(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ctl", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    chk("mid_rst_fu",  32'({fu_in, fu_weight, fu_s_in, fu_s_weight}), 32'd0);
    do_pair(mk(8'h02, 8'h03, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 0, 1), lat, res);
    chk("mid_rst_next_data", res, 32'd6);
    chk("mid_rst_next_lat",  32'(lat), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, %0d/%0d so far", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

endmodule
